// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Contents:
//   parity_e        - parity mode selector for transmit/receive blocks
//   uart_tx_state_e - transmitter frame state
//   parity_bit()    - parity bit value for a mode, given the XOR of the data bits
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_ODD  = 2'd1,
    PARITY_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  // Even parity repeats the data XOR; odd parity inverts it.
  function automatic logic parity_bit(input parity_e mode, input logic data_xor);
    logic bit_s;
    case (mode)
      PARITY_EVEN: bit_s = data_xor;
      PARITY_ODD:  bit_s = ~data_xor;
      default:     bit_s = 1'b0;
    endcase
    return bit_s;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: down-counter loaded with a divisor, reloading from the
// divisor captured at the last load, so later divisor changes are ignored
// until the next load.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   load       capture divisor and restart the bit period
//   divisor    bit period minus one, in clk cycles
//   tick       high in the last cycle of each bit period
//   tick_next  tick value the counter will present in the following cycle
module uart_bit_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 tick,
  output logic                 tick_next
);

  logic [DIV_WIDTH-1:0] div_r;
  logic [DIV_WIDTH-1:0] cnt_r;

  // Counter: load on request, reload at zero, otherwise count down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r <= DIV_WIDTH'(0);
      cnt_r <= DIV_WIDTH'(0);
    end else if (load) begin
      div_r <= divisor;
      cnt_r <= divisor;
    end else if (cnt_r == DIV_WIDTH'(0)) begin
      cnt_r <= div_r;
    end else begin
      cnt_r <= cnt_r - DIV_WIDTH'(1);
    end
  end

  assign tick = (cnt_r == DIV_WIDTH'(0));

  // Look-ahead lets the transmitter register flags that must be valid in the
  // final cycle of a period, including 1-cycle periods.
  always_comb begin
    if (load) begin
      tick_next = (divisor == DIV_WIDTH'(0));
    end else if (tick) begin
      tick_next = (div_r == DIV_WIDTH'(0));
    end else begin
      tick_next = (cnt_r == DIV_WIDTH'(1));
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter. Accepts one word per valid/ready transfer and sends a
// frame: start bit, data LSB first, optional parity, STOP_BITS stop bits.
// Ports:
//   clk, rst  transmit clock, asynchronous active-high reset
//   divisor   bit period minus one (captured at each transfer)
//   in_valid  / in_ready / in_data   input stream
//   tx        serial line, idle high
//   busy      frame in progress
module uart_tx
  import uart_pkg::*;
#(
  parameter int      DATA_BITS = 8,
  parameter int      DIV_WIDTH = 16,
  parameter parity_e PARITY    = PARITY_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 tx,
  output logic                 busy
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_tx: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx: STOP_BITS must be 1..2");
  end

  localparam int             IDX_W      = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic           STOP_LAST  = 1'(STOP_BITS - 1);
  localparam logic           HAS_PARITY = (PARITY != PARITY_NONE);

  uart_tx_state_e       state_r, state_next_s;
  logic [DATA_BITS-1:0] shift_r, shift_next_s;
  logic                 parity_r, parity_next_s;
  logic [IDX_W-1:0]     bit_idx_r, bit_idx_next_s;
  logic                 stop_idx_r, stop_idx_next_s;
  logic                 tx_r, tx_next_s;
  logic                 busy_r, busy_next_s;
  logic                 in_ready_r, in_ready_next_s;
  logic                 xfer_s, tick_s, tick_next_s;

  assign xfer_s   = in_valid & in_ready_r;
  assign tx       = tx_r;
  assign busy     = busy_r;
  assign in_ready = in_ready_r;

  uart_bit_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (xfer_s),
    .divisor   (divisor),
    .tick      (tick_s),
    .tick_next (tick_next_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; the last stop bit chains straight into START on a transfer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) state_next_s = START;
        else        state_next_s = IDLE;
      end
      START: begin
        if (tick_s) state_next_s = DATA;
        else        state_next_s = START;
      end
      DATA: begin
        if (tick_s && bit_idx_r == LAST_IDX) begin
          if (HAS_PARITY) state_next_s = uart_pkg::PARITY;
          else            state_next_s = STOP;
        end else begin
          state_next_s = DATA;
        end
      end
      uart_pkg::PARITY: begin
        if (tick_s) state_next_s = STOP;
        else        state_next_s = uart_pkg::PARITY;
      end
      STOP: begin
        if (tick_s && stop_idx_r == STOP_LAST) begin
          if (xfer_s) state_next_s = START;
          else        state_next_s = IDLE;
        end else begin
          state_next_s = STOP;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output and datapath next values; tx is set one edge ahead so it is registered.
  always_comb begin
    tx_next_s       = tx_r;
    shift_next_s    = shift_r;
    parity_next_s   = parity_r;
    bit_idx_next_s  = bit_idx_r;
    stop_idx_next_s = stop_idx_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) tx_next_s = 1'b0;
        else        tx_next_s = 1'b1;
      end
      START: begin
        if (tick_s) tx_next_s = shift_r[0];
        else        tx_next_s = 1'b0;
      end
      DATA: begin
        if (tick_s) begin
          if (bit_idx_r == LAST_IDX) begin
            if (HAS_PARITY) tx_next_s = parity_r;
            else            tx_next_s = 1'b1;
          end else begin
            tx_next_s      = shift_r[1];
            shift_next_s   = shift_r >> 1;
            bit_idx_next_s = bit_idx_r + IDX_W'(1);
          end
        end else begin
          tx_next_s = tx_r;
        end
      end
      uart_pkg::PARITY: begin
        if (tick_s) tx_next_s = 1'b1;
        else        tx_next_s = tx_r;
      end
      STOP: begin
        if (tick_s && stop_idx_r == STOP_LAST) begin
          if (xfer_s) tx_next_s = 1'b0;
          else        tx_next_s = 1'b1;
        end else if (tick_s) begin
          tx_next_s       = 1'b1;
          stop_idx_next_s = 1'b1;
        end else begin
          tx_next_s = 1'b1;
        end
      end
      default: tx_next_s = 1'b1;
    endcase
    // A transfer only happens in IDLE or the final stop cycle, so it never
    // collides with the shift/counter updates above.
    if (xfer_s) begin
      shift_next_s    = in_data;
      parity_next_s   = parity_bit(PARITY, ^in_data);
      bit_idx_next_s  = IDX_W'(0);
      stop_idx_next_s = 1'b0;
    end else begin
      parity_next_s = parity_r;
    end
    busy_next_s     = (state_next_s != IDLE);
    in_ready_next_s = (state_next_s == IDLE) ||
                      (state_next_s == STOP && stop_idx_next_s == STOP_LAST && tick_next_s);
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      in_ready_r <= 1'b0;
      shift_r    <= DATA_BITS'(0);
      parity_r   <= 1'b0;
      bit_idx_r  <= IDX_W'(0);
      stop_idx_r <= 1'b0;
    end else begin
      tx_r       <= tx_next_s;
      busy_r     <= busy_next_s;
      in_ready_r <= in_ready_next_s;
      shift_r    <= shift_next_s;
      parity_r   <= parity_next_s;
      bit_idx_r  <= bit_idx_next_s;
      stop_idx_r <= stop_idx_next_s;
    end
  end

endmodule
